// File: rtl/regfile_mp.sv
// regfile_mp: DEPTH x WIDTH register file, one write port, two registered read ports, per-entry valid bits.
// Optional write-first forwarding on same-address collisions: define REGFILE_MP_WR_BYPASS_EN.
module regfile_mp #(
   parameter int WIDTH = 11,
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   output logic             wr_err,
   input  logic             rd0_en,
   input  logic [AW-1:0]    rd0_addr,
   output logic [WIDTH-1:0] rd0_data,
   output logic             rd0_vld,
   output logic             rd0_ack,
   input  logic             rd1_en,
   input  logic [AW-1:0]    rd1_addr,
   output logic [WIDTH-1:0] rd1_data,
   output logic             rd1_vld,
   output logic             rd1_ack
);
   localparam int NP = 2;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [DEPTH-1:0] valid_q, valid_d;
   logic [WIDTH-1:0] rd_data_q [NP];
   logic [WIDTH-1:0] rd_data_d [NP];
   logic [NP-1:0]    rd_vld_q, rd_vld_d, rd_ack_q, rd_ack_d;
   logic             wr_err_q, wr_err_d, wr_ok;
   logic [NP-1:0]    rd_en;
   logic [AW-1:0]    rd_addr [NP];

   function automatic logic in_range(input logic [AW-1:0] a);
      return int'(a) < DEPTH;
   endfunction

   assign rd_en      = {rd1_en, rd0_en};
   assign rd_addr[0] = rd0_addr;
   assign rd_addr[1] = rd1_addr;

   always_comb begin
      wr_ok    = wr_en && in_range(wr_addr);
      wr_err_d = wr_en && !in_range(wr_addr);
      mem_d    = mem_q;
      valid_d  = clr ? '0 : valid_q;
      // the write lands after the clear so a clr+write entry ends valid
      if (wr_ok) begin
         mem_d[wr_addr]   = wr_data;
         valid_d[wr_addr] = 1'b1;
      end
      for (int p = 0; p < NP; p++) begin
         rd_data_d[p] = rd_data_q[p];
         rd_vld_d[p]  = rd_vld_q[p];
         rd_ack_d[p]  = rd_en[p];
         if (rd_en[p]) begin
            rd_data_d[p] = in_range(rd_addr[p]) ? mem_q[rd_addr[p]] : '0;
            rd_vld_d[p]  = in_range(rd_addr[p]) && valid_q[rd_addr[p]];
`ifdef REGFILE_MP_WR_BYPASS_EN
            if (wr_ok && wr_addr == rd_addr[p]) begin
               rd_data_d[p] = wr_data;
               rd_vld_d[p]  = 1'b1;
            end
`endif
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_q     <= '{default: '0};
         valid_q   <= '0;
         rd_data_q <= '{default: '0};
         rd_vld_q  <= '0;
         rd_ack_q  <= '0;
         wr_err_q  <= 1'b0;
      end else begin
         mem_q     <= mem_d;
         valid_q   <= valid_d;
         rd_data_q <= rd_data_d;
         rd_vld_q  <= rd_vld_d;
         rd_ack_q  <= rd_ack_d;
         wr_err_q  <= wr_err_d;
      end
   end

   assign wr_err   = wr_err_q;
   assign rd0_data = rd_data_q[0];
   assign rd0_vld  = rd_vld_q[0];
   assign rd0_ack  = rd_ack_q[0];
   assign rd1_data = rd_data_q[1];
   assign rd1_vld  = rd_vld_q[1];
   assign rd1_ack  = rd_ack_q[1];
endmodule
